// File: rtl/alu_issue_ctrl_if.sv
// Request, ALU-side and result signals of alu_issue_ctrl.
// The controller takes the slave modport and the requester/ALU environment takes the master modport.
interface alu_issue_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [2:0]       in_op;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_s;
  logic             alu_reset;
  logic [WIDTH-1:0] alu_result;
  logic             alu_done;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [2:0]       out_op;
  logic             out_err;
  logic             busy;

  modport slave (
    input  in_valid, in_a, in_b, in_op, alu_result, alu_done, out_ready,
    output in_ready, alu_a, alu_b, alu_s, alu_reset, out_valid, out_data, out_op, out_err, busy
  );

  modport master (
    output in_valid, in_a, in_b, in_op, alu_result, alu_done, out_ready,
    input  in_ready, alu_a, alu_b, alu_s, alu_reset, out_valid, out_data, out_op, out_err, busy
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue sequencer in front of the 32-bit ALU: holds operands, restarts the mod unit, returns one registered result.
// Optional MOD_WAIT abort counter is enabled with `define ALU_ISSUE_TIMEOUT_EN.
module alu_issue_ctrl #(
  parameter int WIDTH       = 32,
  parameter int MOD_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  alu_issue_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE,
    COMB,
    MOD_START,
    MOD_WAIT,
    DONE
  } state_t;

  localparam logic [2:0] OP_MOD = 3'b111;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       s_q, s_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [2:0]       op_q, op_d;
  logic             settle_q, settle_d;
  logic             pulse_q, pulse_d;

`ifdef ALU_ISSUE_TIMEOUT_EN
  localparam int CW = (MOD_TIMEOUT < 2) ? 1 : $clog2(MOD_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MOD_TIMEOUT - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`endif

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    s_d      = s_q;
    data_d   = data_q;
    op_d     = op_q;
    settle_d = 1'b0;
`ifdef ALU_ISSUE_TIMEOUT_EN
    cnt_d    = cnt_q;
    err_d    = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.in_a;
          b_d     = bus.in_b;
          s_d     = bus.in_op;
          state_d = (bus.in_op == OP_MOD) ? MOD_START : COMB;
        end
      end
      COMB: begin
        // First cycle only lets the combinational ALU path settle.
        if (!settle_q) begin
          settle_d = 1'b1;
        end else begin
          data_d  = bus.alu_result;
          op_d    = s_q;
          state_d = DONE;
        end
      end
      MOD_START: begin
        state_d = MOD_WAIT;
`ifdef ALU_ISSUE_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      MOD_WAIT: begin
        if (bus.alu_done) begin
          data_d  = bus.alu_result;
          op_d    = s_q;
          state_d = DONE;
`ifdef ALU_ISSUE_TIMEOUT_EN
          err_d   = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          data_d  = '0;
          op_d    = s_q;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
`endif
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
`ifdef ALU_ISSUE_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    // Registered so the mod-unit reset pulse comes straight off a flop.
    pulse_d = (state_d == MOD_START);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      s_q      <= '0;
      data_q   <= '0;
      op_q     <= '0;
      settle_q <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      s_q      <= s_d;
      data_q   <= data_d;
      op_q     <= op_d;
      settle_q <= settle_d;
      pulse_q  <= pulse_d;
    end
  end

`ifdef ALU_ISSUE_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign bus.out_err = err_q;
`else
  assign bus.out_err = 1'b0;
`endif

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_data  = data_q;
  assign bus.out_op    = op_q;
  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.alu_s     = s_q;
  assign bus.alu_reset = reset | pulse_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a behavioural ALU/mod-unit stub (done 10 cycles after alu_reset drops).
module tb_alu_issue_ctrl;
  localparam int W = 32;
  localparam int MOD_LAT = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alu_issue_ctrl_if #(.WIDTH(W)) bus ();

  alu_issue_ctrl #(.WIDTH(W), .MOD_TIMEOUT(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  function automatic logic [W-1:0] alu_model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] s);
    case (s)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return a << b[4:0];
      3'd6:    return ~a;
      default: return (b == '0) ? '0 : a % b;
    endcase
  endfunction

  // ALU / mod unit stub
  logic [3:0] mod_cnt;
  bit done_force_hi = 1'b0;
  bit done_block    = 1'b0;
  always_ff @(posedge clk) begin
    if (bus.alu_reset) mod_cnt <= '0;
    else if (mod_cnt != 4'(MOD_LAT)) mod_cnt <= mod_cnt + 1'b1;
  end
  assign bus.alu_done   = !done_block && (done_force_hi || mod_cnt == 4'(MOD_LAT));
  assign bus.alu_result = alu_model(bus.alu_a, bus.alu_b, bus.alu_s);

  typedef struct {
    logic [W-1:0] data;
    logic [2:0]   op;
    logic         err;
  } exp_t;
  exp_t sb[$];

  int n_chk  = 0;
  int n_fail = 0;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_op     = '0;
    bus.out_ready = 1'b0;
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op, input bit exp_to);
    exp_t e;
    int   w;
    w = 0;
    bus.in_valid = 1'b1;
    bus.in_a = a;
    bus.in_b = b;
    bus.in_op = op;
    while (!bus.in_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    if (!bus.in_ready) begin
      n_chk++; n_fail++;
      $display("FAIL send_ready: in_ready=%0b after %0d cycles, required 1", bus.in_ready, w);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    e.data = exp_to ? '0 : alu_model(a, b, op);
    e.op   = op;
    e.err  = exp_to;
    sb.push_back(e);
  endtask

  task automatic wait_valid(input int max, output int lat, output bit ok, output bit rst_seen);
    lat = 0; ok = 1'b0; rst_seen = 1'b0;
    while (lat < max && !ok) begin
      @(posedge clk); #1; lat++;
      if (bus.alu_reset) rst_seen = 1'b1;
      if (bus.out_valid) ok = 1'b1;
    end
  endtask

  task automatic handshake();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %0b want 0", bus.out_valid); end
    n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %0b want 0", bus.busy); end
    n_chk++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %0b want 1", bus.in_ready); end
    n_chk++; if (bus.alu_reset !== 1'b1) begin n_fail++; $display("FAIL rst_alu_reset: got %0b want 1", bus.alu_reset); end
    n_chk++; if (bus.out_data !== '0 || bus.alu_a !== '0 || bus.alu_b !== '0) begin
      n_fail++; $display("FAIL rst_data: out_data=%h alu_a=%h alu_b=%h want 0", bus.out_data, bus.alu_a, bus.alu_b);
    end
    n_chk++; if (bus.alu_s !== 3'd0 || bus.out_op !== 3'd0 || bus.out_err !== 1'b0) begin
      n_fail++; $display("FAIL rst_ops: alu_s=%0d out_op=%0d out_err=%0b want 0", bus.alu_s, bus.out_op, bus.out_err);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    n_chk++; if (bus.alu_reset !== 1'b0) begin n_fail++; $display("FAIL rst_release: alu_reset=%0b want 0", bus.alu_reset); end
  endtask

  task automatic test_comb();
    logic [2:0]   ops [4];
    logic [W-1:0] a, b;
    exp_t e;
    int   lat;
    bit   ok, rs;
    ops = '{3'd0, 3'd1, 3'd2, 3'd5};
    for (int i = 0; i < 4; i++) begin
      a = (i == 0) ? W'(5) : W'($urandom);
      b = (i == 0) ? W'(3) : W'($urandom_range(0, 40));
      send(a, b, ops[i], 1'b0);
      wait_valid(20, lat, ok, rs);
      e = sb.pop_front();
      n_chk++; if (!ok || lat != 2) begin n_fail++; $display("FAIL comb_latency[%0d]: ok=%0b lat=%0d want 2", i, ok, lat); end
      n_chk++; if (bus.out_data !== e.data) begin n_fail++; $display("FAIL comb_data[%0d]: got %h want %h", i, bus.out_data, e.data); end
      n_chk++; if (bus.out_op !== e.op || bus.out_err !== 1'b0) begin
        n_fail++; $display("FAIL comb_op[%0d]: op=%0d err=%0b want op=%0d err=0", i, bus.out_op, bus.out_err, e.op);
      end
      n_chk++; if (rs) begin n_fail++; $display("FAIL comb_alu_reset[%0d]: alu_reset pulsed, want none", i); end
      handshake();
      n_chk++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        n_fail++; $display("FAIL comb_release[%0d]: out_valid=%0b in_ready=%0b want 0/1", i, bus.out_valid, bus.in_ready);
      end
    end
  endtask

  task automatic test_mod();
    exp_t e;
    int   lat;
    bit   ok, rs;
    send(W'(100), W'(7), 3'b111, 1'b0);
    n_chk++; if (bus.alu_reset !== 1'b1 || bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL mod_pulse: alu_reset=%0b busy=%0b want 1/1", bus.alu_reset, bus.busy);
    end
    wait_valid(40, lat, ok, rs);
    e = sb.pop_front();
    n_chk++; if (rs) begin n_fail++; $display("FAIL mod_pulse_width: alu_reset high past 1 cycle"); end
    n_chk++; if (!ok || lat != MOD_LAT + 2) begin n_fail++; $display("FAIL mod_latency: ok=%0b lat=%0d want %0d", ok, lat, MOD_LAT + 2); end
    n_chk++; if (bus.out_data !== W'(2) || e.data !== W'(2)) begin n_fail++; $display("FAIL mod_data: got %0d want 2", bus.out_data); end
    n_chk++; if (bus.out_op !== 3'b111 || bus.out_err !== 1'b0) begin
      n_fail++; $display("FAIL mod_op: op=%0d err=%0b want 7/0", bus.out_op, bus.out_err);
    end
    handshake();
  endtask

  task automatic test_back_pressure();
    exp_t e;
    int   lat;
    bit   ok, rs, bad;
    send(W'(32'hA5A5_0F0F), W'(32'h0FF0_1234), 3'd4, 1'b0);
    wait_valid(20, lat, ok, rs);
    e = sb.pop_front();
    n_chk++; if (!ok) begin n_fail++; $display("FAIL bp_valid: out_valid never rose"); end
    bus.in_valid = 1'b1;
    bus.in_a = W'(32'hDEAD_BEEF);
    bus.in_b = W'(1);
    bus.in_op = 3'd0;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b1 || bus.out_data !== e.data || bus.in_ready !== 1'b0 ||
          bus.alu_a !== W'(32'hA5A5_0F0F)) begin
        bad = 1'b1;
        $display("FAIL bp_hold[%0d]: valid=%0b data=%h ready=%0b alu_a=%h want 1/%h/0/a5a50f0f",
                 i, bus.out_valid, bus.out_data, bus.in_ready, bus.alu_a, e.data);
      end
    end
    n_chk++; if (bad) n_fail++;
    bus.in_valid = 1'b0;
    handshake();
    n_chk++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.alu_a !== W'(32'hA5A5_0F0F)) begin
      n_fail++; $display("FAIL bp_release: in_ready=%0b out_valid=%0b alu_a=%h want 1/0/a5a50f0f",
                         bus.in_ready, bus.out_valid, bus.alu_a);
    end
  endtask

  task automatic test_stale_done();
    exp_t e;
    int   lat;
    bit   ok, rs;
    done_force_hi = 1'b1;
    send(W'(20), W'(6), 3'd3, 1'b0);
    wait_valid(20, lat, ok, rs);
    e = sb.pop_front();
    n_chk++; if (!ok || lat != 2 || bus.out_data !== e.data) begin
      n_fail++; $display("FAIL stale_comb: ok=%0b lat=%0d data=%h want lat 2 data %h", ok, lat, bus.out_data, e.data);
    end
    handshake();
    done_force_hi = 1'b0;
    send(W'(1000), W'(33), 3'b111, 1'b0);
    wait_valid(40, lat, ok, rs);
    e = sb.pop_front();
    n_chk++; if (!ok || lat != MOD_LAT + 2) begin
      n_fail++; $display("FAIL stale_mod_latency: ok=%0b lat=%0d want %0d", ok, lat, MOD_LAT + 2);
    end
    n_chk++; if (bus.out_data !== e.data || bus.out_op !== 3'b111) begin
      n_fail++; $display("FAIL stale_mod_data: data=%0d op=%0d want %0d/7", bus.out_data, bus.out_op, e.data);
    end
    handshake();
  endtask

  task automatic test_reset_mid_op();
    bit seen;
    send(W'(50), W'(9), 3'b111, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    n_chk++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst_state: busy=%0b in_ready=%0b out_valid=%0b want 0/1/0",
                         bus.busy, bus.in_ready, bus.out_valid);
    end
    n_chk++; if (bus.alu_reset !== 1'b1 || bus.alu_a !== '0) begin
      n_fail++; $display("FAIL mid_rst_alu: alu_reset=%0b alu_a=%h want 1/0", bus.alu_reset, bus.alu_a);
    end
    @(posedge clk); #1;
    n_chk++; if (bus.alu_reset !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst_hold: alu_reset=%0b busy=%0b want 1/0", bus.alu_reset, bus.busy);
    end
    reset = 1'b0;
    void'(sb.pop_back());
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid || bus.busy) seen = 1'b1;
    end
    n_chk++; if (seen) begin n_fail++; $display("FAIL mid_rst_discard: out_valid/busy after reset, want none"); end
  endtask

`ifdef ALU_ISSUE_TIMEOUT_EN
  task automatic test_timeout();
    exp_t e;
    int   lat;
    bit   ok, rs;
    done_block = 1'b1;
    send(W'(123), W'(4), 3'b111, 1'b1);
    wait_valid(40, lat, ok, rs);
    e = sb.pop_front();
    n_chk++; if (!ok || lat != 9) begin n_fail++; $display("FAIL to_latency: ok=%0b lat=%0d want 9", ok, lat); end
    n_chk++; if (bus.out_err !== e.err || bus.out_data !== e.data || bus.out_op !== e.op) begin
      n_fail++; $display("FAIL to_result: err=%0b data=%h op=%0d want 1/0/7", bus.out_err, bus.out_data, bus.out_op);
    end
    handshake();
    n_chk++; if (bus.out_err !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL to_clear: out_err=%0b in_ready=%0b want 0/1", bus.out_err, bus.in_ready);
    end
    done_block = 1'b0;
  endtask
`else
  task automatic test_no_timeout();
    exp_t e;
    int   lat;
    bit   ok, rs;
    done_block = 1'b1;
    send(W'(77), W'(10), 3'b111, 1'b0);
    wait_valid(80, lat, ok, rs);
    n_chk++; if (ok) begin n_fail++; $display("FAIL nto_wait: out_valid after %0d cycles without done, want none", lat); end
    done_block = 1'b0;
    wait_valid(5, lat, ok, rs);
    e = sb.pop_front();
    n_chk++; if (!ok || lat != 1 || bus.out_data !== e.data || bus.out_err !== 1'b0) begin
      n_fail++; $display("FAIL nto_done: ok=%0b lat=%0d data=%0d err=%0b want 1/1/%0d/0", ok, lat, bus.out_data, bus.out_err, e.data);
    end
    handshake();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_comb();
    test_mod();
    test_back_pressure();
    test_stale_done();
    test_reset_mid_op();
`ifdef ALU_ISSUE_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
